// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter
//   Gives the core fetch path and the I2C programming port shared use of the
//   single-port instruction memory. Every access is a fixed three-cycle
//   sequence: grant, access, response. The arbiter also makes the core halt
//   signal from the synchronized program-mode pad.
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_prog_mode         async pad: 1 = programming, 0 = running
//   i_fetch_req/addr    fetch request (level, held until o_fetch_valid)
//   o_fetch_valid/data  one-cycle fetch response and the fetched word
//   i_i2c_req/we/addr/wdata  I2C request (level, held until o_i2c_ack)
//   o_i2c_ack/err/rdata one-cycle I2C response; err marks a rejected write
//   o_mem_addr/we/wdata memory address, write strobe and write byte
//   i_mem_rdata         memory read data, one cycle after o_mem_addr
//   o_halt              core stall, registered synchronized program mode
module inst_mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WR_W     = 8,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_prog_mode,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [DATA_W-1:0] o_fetch_data,
  input  logic              i_i2c_req,
  input  logic              i_i2c_we,
  input  logic [ADDR_W-1:0] i_i2c_addr,
  input  logic [WR_W-1:0]   i_i2c_wdata,
  output logic              o_i2c_ack,
  output logic              o_i2c_err,
  output logic [WR_W-1:0]   o_i2c_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [WR_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_halt
);

  localparam int unsigned    CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, REJECT} state_t;

  state_t           state, state_d;
  logic             pm_meta, pm_s;
  logic             cur_i2c;
  logic [CNT_W-1:0] wait_cnt, wait_d;
  logic             grant_fetch, grant_i2c, reject;
  logic             rd_pending;

  // Next-state and grant decision; mode is only looked at in IDLE so a
  // mode change never disturbs a transaction already in flight.
  always_comb begin
    state_d     = state;
    grant_fetch = 1'b0;
    grant_i2c   = 1'b0;
    reject      = 1'b0;
    case (state)
      IDLE: begin
        if (pm_s) begin
          if (i_i2c_req) begin
            grant_i2c = 1'b1;
            state_d   = ACCESS;
          end
        end else if (i_i2c_req && i_i2c_we) begin
          reject  = 1'b1;
          state_d = REJECT;
        end else if (i_i2c_req && (wait_cnt == WAIT_MAX || !i_fetch_req)) begin
          grant_i2c = 1'b1;
          state_d   = ACCESS;
        end else if (i_fetch_req) begin
          grant_fetch = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read that is already being served is not "waiting".
  assign rd_pending = i_i2c_req && !i_i2c_we &&
                      !(cur_i2c && (state == ACCESS || state == RESP));

  always_comb begin
    wait_d = wait_cnt;
    if (pm_s || !i_i2c_req || grant_i2c) begin
      wait_d = '0;
    end else if (rd_pending && wait_cnt != WAIT_MAX) begin
      wait_d = wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pm_meta       <= 1'b0;
      pm_s          <= 1'b0;
      o_halt        <= 1'b0;
      cur_i2c       <= 1'b0;
      o_fetch_valid <= 1'b0;
      o_fetch_data  <= '0;
      o_i2c_ack     <= 1'b0;
      o_i2c_err     <= 1'b0;
      o_i2c_rdata   <= '0;
      o_mem_addr    <= '0;
      o_mem_we      <= 1'b0;
      o_mem_wdata   <= '0;
    end else begin
      pm_meta       <= i_prog_mode;
      pm_s          <= pm_meta;
      o_halt        <= pm_s;
      o_fetch_valid <= 1'b0;
      o_i2c_ack     <= 1'b0;
      o_i2c_err     <= 1'b0;
      o_mem_we      <= 1'b0;
      if (grant_fetch) begin
        o_mem_addr <= i_fetch_addr;
        cur_i2c    <= 1'b0;
      end
      if (grant_i2c) begin
        o_mem_addr  <= i_i2c_addr;
        o_mem_we    <= i_i2c_we;
        o_mem_wdata <= i_i2c_wdata;
        cur_i2c     <= 1'b1;
      end
      if (reject) begin
        o_i2c_ack <= 1'b1;
        o_i2c_err <= 1'b1;
      end
      // Capture at the end of ACCESS; the pulse then covers the RESP cycle.
      if (state == ACCESS) begin
        if (cur_i2c) begin
          o_i2c_ack   <= 1'b1;
          o_i2c_rdata <= i_mem_rdata[WR_W-1:0];
        end else begin
          o_fetch_valid <= 1'b1;
          o_fetch_data  <= i_mem_rdata;
        end
      end
    end
  end

endmodule
